// File: rtl/gcm_disp_pkg.sv
// Shared types and the page-to-word selection used by the GCM result pager.
package gcm_disp_pkg;

    localparam int unsigned NUM_PAGES = 16;
    localparam int unsigned CT_PAGES  = 8;
    localparam int unsigned WORD_W    = 16;

    typedef logic [3:0] page_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        SHOW  = 1'b1
    } pager_state_t;

    // Bit 0 of each captured vector lands on the MSB of the returned word.
    function automatic logic [WORD_W-1:0] page_word(
        input logic [0:127] ct,
        input logic [0:127] tag,
        input page_t        p
    );
        logic [6:0] base;
        base = {p[2:0], 4'b0000};
        if (p >= page_t'(CT_PAGES)) begin
            page_word = tag[base +: WORD_W];
        end else begin
            page_word = ct[base +: WORD_W];
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, accepted level
// and a single-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // A new level is accepted only after it differs from the old one for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            pulse   <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                pulse   <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gcm_result_pager.sv
// Captures the GCM ciphertext/tag on result-valid and pages the 256 bits to a
// 16-bit display, stepped by debounced buttons or an auto-advance timer.
module gcm_result_pager
    import gcm_disp_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned AUTO_PERIOD     = 50_000_000
) (
    input  logic         clk,
    input  logic         i_reset_n,
    input  logic [0:127] i_cipher_text,
    input  logic [0:127] i_tag,
    input  logic         i_tag_ready,
    input  logic         i_btn_next,
    input  logic         i_btn_prev,
    input  logic         i_auto_en,
    output logic [15:0]  o_disp_data,
    output logic [3:0]   o_page,
    output logic         o_refresh,
    output logic         o_valid
);

    localparam int unsigned TIMER_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(AUTO_PERIOD - 1);

    pager_state_t        state_q, state_d;
    logic [0:127]        ct_q, ct_d;
    logic [0:127]        tag_q, tag_d;
    page_t               page_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [WORD_W-1:0]   disp_d;
    logic                refresh_d;
    logic                valid_d;
    logic                tag_ready_q;
    logic                auto_sync_q, auto_q;
    logic                next_pulse, prev_pulse;
    logic                tag_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk   (clk),
        .rst_n (i_reset_n),
        .btn   (i_btn_next),
        .pulse (next_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk   (clk),
        .rst_n (i_reset_n),
        .btn   (i_btn_prev),
        .pulse (prev_pulse)
    );

    // Reset value 0 lets a result already valid at reset release count as an edge.
    assign tag_rise = i_tag_ready & ~tag_ready_q;

    // Priority: capture, then a single accepted button, then the auto timer.
    always_comb begin
        state_d   = state_q;
        ct_d      = ct_q;
        tag_d     = tag_q;
        page_d    = o_page;
        timer_d   = timer_q;
        valid_d   = o_valid;
        refresh_d = 1'b0;
        if (tag_rise) begin
            state_d   = SHOW;
            ct_d      = i_cipher_text;
            tag_d     = i_tag;
            page_d    = '0;
            timer_d   = '0;
            valid_d   = 1'b1;
            refresh_d = 1'b1;
        end else if (state_q == SHOW) begin
            if (next_pulse ^ prev_pulse) begin
                page_d    = next_pulse ? o_page + page_t'(1) : o_page - page_t'(1);
                timer_d   = '0;
                refresh_d = 1'b1;
            end else if (!auto_q) begin
                timer_d = '0;
            end else if (timer_q == TIMER_LAST) begin
                page_d    = o_page + page_t'(1);
                timer_d   = '0;
                refresh_d = 1'b1;
            end else begin
                timer_d = timer_q + TIMER_W'(1);
            end
        end
        disp_d = page_word(ct_d, tag_d, page_d);
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= EMPTY;
            ct_q        <= '0;
            tag_q       <= '0;
            timer_q     <= '0;
            tag_ready_q <= 1'b0;
            auto_sync_q <= 1'b0;
            auto_q      <= 1'b0;
            o_disp_data <= '0;
            o_page      <= '0;
            o_refresh   <= 1'b0;
            o_valid     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ct_q        <= ct_d;
            tag_q       <= tag_d;
            timer_q     <= timer_d;
            tag_ready_q <= i_tag_ready;
            auto_sync_q <= i_auto_en;
            auto_q      <= auto_sync_q;
            o_disp_data <= disp_d;
            o_page      <= page_d;
            o_refresh   <= refresh_d;
            o_valid     <= valid_d;
        end
    end

endmodule

// File: tb/tb_gcm_result_pager.sv
// Directed bench for gcm_result_pager with short debounce and auto periods.
module tb_gcm_result_pager;

    localparam logic [127:0] CT1  = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    localparam logic [127:0] TAG1 = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
    localparam logic [127:0] CT2  = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
    localparam logic [127:0] TAG2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    logic         clk = 1'b0;
    logic         i_reset_n;
    logic [127:0] i_cipher_text;
    logic [127:0] i_tag;
    logic         i_tag_ready;
    logic         i_btn_next;
    logic         i_btn_prev;
    logic         i_auto_en;
    logic [15:0]  o_disp_data;
    logic [3:0]   o_page;
    logic         o_refresh;
    logic         o_valid;

    int errors = 0;
    int checks = 0;
    int refresh_cnt = 0;
    int exp_page = 0;
    logic [127:0] cur_ct;
    logic [127:0] cur_tag;

    gcm_result_pager #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8)) dut (
        .clk           (clk),
        .i_reset_n     (i_reset_n),
        .i_cipher_text (i_cipher_text),
        .i_tag         (i_tag),
        .i_tag_ready   (i_tag_ready),
        .i_btn_next    (i_btn_next),
        .i_btn_prev    (i_btn_prev),
        .i_auto_en     (i_auto_en),
        .o_disp_data   (o_disp_data),
        .o_page        (o_page),
        .o_refresh     (o_refresh),
        .o_valid       (o_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (o_refresh === 1'b1) refresh_cnt++;
    end

    function automatic logic [15:0] exp_word(input logic [127:0] ct, input logic [127:0] tg, input int p);
        if (p < 8) return ct[127-16*p -: 16];
        return tg[127-16*(p-8) -: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_refresh(input int budget, output int n, output bit seen);
        seen = 1'b0;
        n = 0;
        while (!seen && n < budget) begin
            tick();
            n++;
            if (o_refresh === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic step_btn(input bit nxt);
        int n;
        bit seen;
        int snap;
        snap = refresh_cnt;
        if (nxt) i_btn_next = 1'b1; else i_btn_prev = 1'b1;
        exp_page = nxt ? (exp_page + 1) % 16 : (exp_page + 15) % 16;
        wait_refresh(20, n, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL step_seen: no refresh within %0d cycles, want page %0d", n, exp_page);
        end
        checks++;
        if (o_page !== 4'(exp_page)) begin
            errors++;
            $display("FAIL step_page: got %0d want %0d", o_page, exp_page);
        end
        checks++;
        if (o_disp_data !== exp_word(cur_ct, cur_tag, exp_page)) begin
            errors++;
            $display("FAIL step_disp: got %h want %h (page %0d)", o_disp_data,
                     exp_word(cur_ct, cur_tag, exp_page), exp_page);
        end
        i_btn_next = 1'b0;
        i_btn_prev = 1'b0;
        repeat (10) tick();
        checks++;
        if (refresh_cnt - snap != 1) begin
            errors++;
            $display("FAIL step_single: got %0d refreshes want 1", refresh_cnt - snap);
        end
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        repeat (3) tick();
        i_reset_n = 1'b1;
        exp_page = 0;
    endtask

    task automatic test_reset();
        i_cipher_text = '0; i_tag = '0; i_tag_ready = 1'b0;
        i_btn_next = 1'b0; i_btn_prev = 1'b0; i_auto_en = 1'b0;
        i_reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({o_disp_data, o_page, o_refresh, o_valid} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got disp=%h page=%0d refresh=%b valid=%b want all 0",
                     o_disp_data, o_page, o_refresh, o_valid);
        end
        i_reset_n = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_refresh !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got valid=%b refresh=%b want 0 0", o_valid, o_refresh);
        end
    endtask

    task automatic test_capture();
        cur_ct = CT1; cur_tag = TAG1;
        i_cipher_text = CT1; i_tag = TAG1;
        i_tag_ready = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_page !== 4'd0 || o_refresh !== 1'b1) begin
            errors++;
            $display("FAIL capture_ctrl: got valid=%b page=%0d refresh=%b want 1 0 1",
                     o_valid, o_page, o_refresh);
        end
        checks++;
        if (o_disp_data !== 16'h0011) begin
            errors++;
            $display("FAIL capture_disp: got %h want 0011", o_disp_data);
        end
        tick();
        checks++;
        if (o_refresh !== 1'b0) begin
            errors++;
            $display("FAIL capture_pulse: got refresh=%b want 0", o_refresh);
        end
        exp_page = 0;
    endtask

    task automatic test_paging();
        step_btn(1'b0);
        step_btn(1'b1);
        for (int i = 0; i < 9; i++) begin
            step_btn(1'b1);
            if (exp_page == 8) begin
                checks++;
                if (o_disp_data !== 16'hA5A5) begin
                    errors++;
                    $display("FAIL page8_tag: got %h want a5a5", o_disp_data);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int snap;
        snap = refresh_cnt;
        for (int i = 0; i < 5; i++) begin
            i_btn_next = (i % 2 == 0);
            repeat (2) tick();
        end
        i_btn_next = 1'b1;
        repeat (20) tick();
        exp_page = (exp_page + 1) % 16;
        checks++;
        if (refresh_cnt - snap != 1 || o_page !== 4'(exp_page)) begin
            errors++;
            $display("FAIL bounce_step: got %0d refreshes page %0d want 1 page %0d",
                     refresh_cnt - snap, o_page, exp_page);
        end
        i_btn_next = 1'b0;
        repeat (10) tick();
        snap = refresh_cnt;
        i_btn_next = 1'b1;
        i_btn_prev = 1'b1;
        repeat (20) tick();
        i_btn_next = 1'b0;
        i_btn_prev = 1'b0;
        repeat (10) tick();
        checks++;
        if (refresh_cnt - snap != 0 || o_page !== 4'(exp_page)) begin
            errors++;
            $display("FAIL both_buttons: got %0d refreshes page %0d want 0 page %0d",
                     refresh_cnt - snap, o_page, exp_page);
        end
    endtask

    task automatic test_auto();
        int n;
        bit seen;
        int snap;
        bit wrapped;
        i_auto_en = 1'b1;
        wait_refresh(30, n, seen);
        exp_page = (exp_page + 1) % 16;
        checks++;
        if (!seen || o_page !== 4'(exp_page)) begin
            errors++;
            $display("FAIL auto_first: seen=%b page %0d want page %0d", seen, o_page, exp_page);
        end
        wrapped = 1'b0;
        for (int i = 0; i < 17 && !wrapped; i++) begin
            wait_refresh(30, n, seen);
            exp_page = (exp_page + 1) % 16;
            if (exp_page == 0) wrapped = 1'b1;
            checks++;
            if (!seen || n != 8 || o_page !== 4'(exp_page)) begin
                errors++;
                $display("FAIL auto_step: interval %0d page %0d want 8 page %0d", n, o_page, exp_page);
            end
        end
        checks++;
        if (!wrapped || o_page !== 4'd0) begin
            errors++;
            $display("FAIL auto_wrap: page %0d want 0", o_page);
        end
        i_btn_next = 1'b1;
        wait_refresh(30, n, seen);
        exp_page = (exp_page + 1) % 16;
        checks++;
        if (!seen || n != 7 || o_page !== 4'(exp_page)) begin
            errors++;
            $display("FAIL auto_btn: at %0d page %0d want 7 page %0d", n, o_page, exp_page);
        end
        i_btn_next = 1'b0;
        wait_refresh(30, n, seen);
        exp_page = (exp_page + 1) % 16;
        checks++;
        if (!seen || n != 8 || o_page !== 4'(exp_page)) begin
            errors++;
            $display("FAIL auto_restart: interval %0d page %0d want 8 page %0d", n, o_page, exp_page);
        end
        i_auto_en = 1'b0;
        snap = refresh_cnt;
        repeat (16) tick();
        checks++;
        if (refresh_cnt - snap != 0) begin
            errors++;
            $display("FAIL auto_off: got %0d refreshes want 0", refresh_cnt - snap);
        end
    endtask

    task automatic test_empty();
        int snap;
        i_tag_ready = 1'b0;
        do_reset();
        snap = refresh_cnt;
        i_btn_next = 1'b1; repeat (12) tick(); i_btn_next = 1'b0; repeat (10) tick();
        i_btn_prev = 1'b1; repeat (12) tick(); i_btn_prev = 1'b0; repeat (10) tick();
        checks++;
        if (o_page !== 4'd0 || o_valid !== 1'b0 || refresh_cnt - snap != 0) begin
            errors++;
            $display("FAIL empty_ignore: page %0d valid %b refreshes %0d want 0 0 0",
                     o_page, o_valid, refresh_cnt - snap);
        end
        cur_ct = CT1; cur_tag = TAG1;
        i_cipher_text = CT1; i_tag = TAG1;
        i_tag_ready = 1'b1;
        repeat (100) tick();
        checks++;
        if (refresh_cnt - snap != 1 || o_valid !== 1'b1 || o_page !== 4'd0) begin
            errors++;
            $display("FAIL held_ready: refreshes %0d valid %b page %0d want 1 1 0",
                     refresh_cnt - snap, o_valid, o_page);
        end
        for (int i = 0; i < 5; i++) step_btn(1'b1);
        i_tag_ready = 1'b0;
        tick();
        cur_ct = CT2; cur_tag = TAG2;
        i_cipher_text = CT2; i_tag = TAG2;
        i_tag_ready = 1'b1;
        tick();
        exp_page = 0;
        checks++;
        if (o_page !== 4'd0 || o_refresh !== 1'b1 || o_disp_data !== 16'hDEAD) begin
            errors++;
            $display("FAIL recapture: page %0d refresh %b disp %h want 0 1 dead",
                     o_page, o_refresh, o_disp_data);
        end
        step_btn(1'b0);
        checks++;
        if (o_disp_data !== 16'h8888) begin
            errors++;
            $display("FAIL recapture_tag: got %h want 8888", o_disp_data);
        end
        step_btn(1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) step_btn(1'b1);
        i_btn_next = 1'b1;
        repeat (3) tick();
        #3;
        i_reset_n = 1'b0;
        #1;
        checks++;
        if ({o_disp_data, o_page, o_refresh, o_valid} !== 22'd0) begin
            errors++;
            $display("FAIL async_reset: got disp=%h page=%0d refresh=%b valid=%b want all 0",
                     o_disp_data, o_page, o_refresh, o_valid);
        end
        i_btn_next = 1'b0;
        cur_ct = CT1; cur_tag = TAG1;
        i_cipher_text = CT1; i_tag = TAG1;
        tick();
        tick();
        i_reset_n = 1'b1;
        exp_page = 0;
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_page !== 4'd0 || o_refresh !== 1'b1 || o_disp_data !== 16'h0011) begin
            errors++;
            $display("FAIL release_capture: valid %b page %0d refresh %b disp %h want 1 0 1 0011",
                     o_valid, o_page, o_refresh, o_disp_data);
        end
        repeat (12) tick();
        checks++;
        if (o_page !== 4'd0) begin
            errors++;
            $display("FAIL release_nostep: page %0d want 0", o_page);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_paging();
        test_bounce();
        test_auto();
        test_empty();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
